handshake_tx_arbiter: RTL and testbench

//  Shares one full_handshake_tx CDC sender between N local requesters, using round-robin arbitration.

---
 rtl/handshake_tx_arbiter.sv | 125 ++++++++++++
 tb/tb_handshake_tx_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/handshake_tx_arbiter.sv
// Round-robin arbiter sharing one 4-phase CDC sender between N requesters.
// It holds each request, issues a 1-cycle tx_req_o and tracks tx_idle_i until the handshake completes.
module handshake_tx_arbiter #(
    parameter int N       = 4,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N-1:0]              src_req_i,
    input  logic [N*DW-1:0]           src_data_i,
    output logic [N-1:0]              src_busy_o,
    output logic [N-1:0]              src_done_o,
    input  logic                      tx_idle_i,
    output logic                      tx_req_o,
    output logic [DW-1:0]             tx_req_data_o,
    output logic [$clog2(N)-1:0]      grant_id_o,
    output logic                      timeout_o,
    input  logic                      timeout_clr_i
);
    localparam int IDW = $clog2(N);
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam logic [IDW:0]   N_WIDE = (IDW + 1)'(N);
    localparam logic [IDW-1:0] LAST   = IDW'(N - 1);
    localparam logic [TW-1:0]  T_MAX  = TW'(TIMEOUT);
    localparam logic [TW-1:0]  T_SET  = TW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        ARB     = 4'b0001,
        ISSUE   = 4'b0010,
        WAIT_LO = 4'b0100,
        WAIT_HI = 4'b1000
    } state_t;

    state_t         state;
    logic [N-1:0]   pend;
    logic [DW-1:0]  hold [N];
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] winner;
    logic [IDW:0]   cand;
    logic           found;
    logic [N-1:0]   done_mask;
    logic           timeout_set;
    logic [TW-1:0]  timer;

    assign src_busy_o = pend;

    // First pending index at ptr, ptr+1, ... wrapping modulo N.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' and give every output a default first, so no latch is inferred.
        winner = ptr;
        found  = 1'b0;
        cand   = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, ptr} + (IDW + 1)'(i);
            if (cand >= N_WIDE) cand = cand - N_WIDE;
            if (!found && pend[cand[IDW-1:0]]) begin
                winner = cand[IDW-1:0];
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        done_mask = '0;
        if (state == WAIT_HI && tx_idle_i) done_mask[grant_id_o] = 1'b1;
    end

    // Fires only on the cycle the timer reaches its limit, so a clear can later stick.
    assign timeout_set = (state == WAIT_LO || state == WAIT_HI) && (timer == T_SET);

    // NOTE: the hold registers are a plain data store with no reset; they are only read while pend marks them valid.
    always_ff @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (src_req_i[k] && !pend[k]) hold[k] <= src_data_i[k*DW +: DW];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ARB;
            pend          <= '0;
            ptr           <= '0;
            timer         <= '0;
            tx_req_o      <= 1'b0;
            tx_req_data_o <= '0;
            grant_id_o    <= '0;
            src_done_o    <= '0;
            timeout_o     <= 1'b0;
        end else begin
            // A requester completing this cycle cannot re-capture: its busy bit is still high.
            pend       <= (pend & ~done_mask) | (src_req_i & ~pend);
            src_done_o <= done_mask;

            if (timeout_set)        timeout_o <= 1'b1;
            else if (timeout_clr_i) timeout_o <= 1'b0;

            unique case (state)
                ARB: begin
                    if (|pend && tx_idle_i) begin
                        tx_req_o      <= 1'b1;
                        tx_req_data_o <= hold[winner];
                        grant_id_o    <= winner;
                        ptr           <= (winner == LAST) ? '0 : winner + IDW'(1);
                        timer         <= '0;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    tx_req_o <= 1'b0;
                    state    <= WAIT_LO;
                end
                WAIT_LO: begin
                    if (timer != T_MAX) timer <= timer + TW'(1);
                    if (!tx_idle_i) state <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (timer != T_MAX) timer <= timer + TW'(1);
                    if (tx_idle_i) state <= ARB;
                end
                default: state <= ARB;
            endcase
        end
    end
endmodule

// File: tb/tb_handshake_tx_arbiter.sv
// Directed bench for handshake_tx_arbiter with a behavioural 4-phase sender (3+3 sync cycles).
// Each scenario task drives its stimulus and compares against hand-computed values.
module tb_handshake_tx_arbiter;
    localparam int N       = 4;
    localparam int DW      = 32;
    localparam int TIMEOUT = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    src_req = '0;
    logic [N*DW-1:0] src_data = '0;
    logic [N-1:0]    src_busy;
    logic [N-1:0]    src_done;
    logic            tx_idle;
    logic            tx_req;
    logic [DW-1:0]   tx_req_data;
    logic [1:0]      grant_id;
    logic            timeout;
    logic            timeout_clr = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    handshake_tx_arbiter #(.N(N), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .src_req_i     (src_req),
        .src_data_i    (src_data),
        .src_busy_o    (src_busy),
        .src_done_o    (src_done),
        .tx_idle_i     (tx_idle),
        .tx_req_o      (tx_req),
        .tx_req_data_o (tx_req_data),
        .grant_id_o    (grant_id),
        .timeout_o     (timeout),
        .timeout_clr_i (timeout_clr)
    );

    always #5 clk = ~clk;

    // Sender: drops idle on the edge it samples req, returns it 6 cycles later unless stuck.
    logic stuck = 1'b0;
    int   s_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_idle <= 1'b1;
            s_cnt   <= 0;
        end else if (tx_idle) begin
            if (tx_req) begin
                tx_idle <= 1'b0;
                s_cnt   <= 0;
            end
        end else if (!stuck) begin
            if (s_cnt == 5) tx_idle <= 1'b1;
            else            s_cnt   <= s_cnt + 1;
        end
    end

    // Event log: 10+k = issue to requester k, 20+k = done for requester k.
    int            ev[$];
    logic [DW-1:0] iss_data[$];
    int            dbl = 0;
    logic          prev_req = 1'b0;
    logic [N-1:0]  prev_done = '0;
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_req) begin
                ev.push_back(10 + int'(grant_id));
                iss_data.push_back(tx_req_data);
                if (prev_req) dbl++;
            end
            for (int k = 0; k < N; k++) if (src_done[k]) ev.push_back(20 + k);
            if ((src_done & prev_done) != '0) dbl++;
            prev_req  = tx_req;
            prev_done = src_done;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [N-1:0] m, input logic [N*DW-1:0] d);
        src_req  = m;
        src_data = d;
        cyc(1);
        src_req  = '0;
        src_data = '0;
    endtask

    task automatic wait_quiet(input int budget, input string name);
        int i;
        for (i = 0; i < budget; i++) begin
            cyc(1);
            if (src_busy == '0) break;
        end
        if (i == budget) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: busy still %b after %0d cycles, required 0000", name, src_busy, budget);
        end
        cyc(2);
    endtask

    task automatic wait_issue(input int budget, input string name);
        int i;
        for (i = 0; i < budget; i++) begin
            cyc(1);
            if (tx_req) break;
        end
        if (i == budget) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: no tx_req within %0d cycles, required a pulse", name, budget);
        end
    endtask

    task automatic test_reset;
        cyc(3);
        n_cmp++; if (src_busy !== 4'b0000) begin n_bad++; $display("FAIL reset_busy: got %b want 0000", src_busy); end
        n_cmp++; if (src_done !== 4'b0000) begin n_bad++; $display("FAIL reset_done: got %b want 0000", src_done); end
        n_cmp++; if (tx_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", tx_req); end
        n_cmp++; if (tx_req_data !== 32'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", tx_req_data); end
        n_cmp++; if (grant_id !== 2'd0) begin n_bad++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
        n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        rst = 1'b0;
        cyc(2);
        n_cmp++; if (tx_req !== 1'b0) begin n_bad++; $display("FAIL idle_req: got %b want 0", tx_req); end
    endtask

    task automatic test_all_same_cycle;
        int exp_ev[$] = '{10, 20, 11, 21, 12, 22, 13, 23};
        ev.delete(); iss_data.delete();
        pulse(4'b1111, {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000});
        n_cmp++; if (src_busy !== 4'b1111) begin n_bad++; $display("FAIL all_busy: got %b want 1111", src_busy); end
        wait_quiet(200, "all_quiet");
        n_cmp++;
        if (ev.size() != exp_ev.size()) begin
            n_bad++; $display("FAIL all_count: got %0d events want %0d", ev.size(), exp_ev.size());
        end else begin
            for (int i = 0; i < exp_ev.size(); i++) begin
                n_cmp++; if (ev[i] != exp_ev[i]) begin n_bad++; $display("FAIL all_order[%0d]: got %0d want %0d", i, ev[i], exp_ev[i]); end
            end
            for (int i = 0; i < 4; i++) begin
                n_cmp++; if (iss_data[i] !== 32'h1000_0000 + 32'(i)) begin n_bad++; $display("FAIL all_data[%0d]: got %h want %h", i, iss_data[i], 32'h1000_0000 + 32'(i)); end
            end
        end
    endtask

    task automatic test_single;
        ev.delete(); iss_data.delete();
        pulse(4'b0010, {32'h0, 32'h0, 32'hA5A5_0001, 32'h0});
        n_cmp++; if (src_busy !== 4'b0010) begin n_bad++; $display("FAIL single_busy: got %b want 0010", src_busy); end
        wait_quiet(60, "single_quiet");
        n_cmp++; if (ev.size() != 2 || ev[0] != 11 || ev[1] != 21) begin n_bad++; $display("FAIL single_events: got %p want '{11,21}", ev); end
        n_cmp++; if (iss_data.size() != 1 || iss_data[0] !== 32'hA5A5_0001) begin n_bad++; $display("FAIL single_data: got %p want a5a50001", iss_data); end
        n_cmp++; if (grant_id !== 2'd1) begin n_bad++; $display("FAIL single_grant: got %0d want 1", grant_id); end
        n_cmp++; if (tx_req_data !== 32'hA5A5_0001) begin n_bad++; $display("FAIL single_data_stable: got %h want a5a50001", tx_req_data); end
        n_cmp++; if (dbl != 0) begin n_bad++; $display("FAIL pulse_width: got %0d multi-cycle pulses want 0", dbl); end
    endtask

    task automatic test_drop_while_busy;
        ev.delete(); iss_data.delete();
        pulse(4'b0100, {32'h0, 32'hB0B0_0002, 32'h0, 32'h0});
        cyc(2);
        n_cmp++; if (src_busy !== 4'b0100) begin n_bad++; $display("FAIL drop_busy: got %b want 0100", src_busy); end
        pulse(4'b0100, {32'h0, 32'h0000_0002, 32'h0, 32'h0});
        wait_quiet(60, "drop_quiet");
        n_cmp++; if (ev.size() != 2 || ev[0] != 12 || ev[1] != 22) begin n_bad++; $display("FAIL drop_events: got %p want '{12,22}", ev); end
        n_cmp++; if (iss_data.size() != 1 || iss_data[0] !== 32'hB0B0_0002) begin n_bad++; $display("FAIL drop_data: got %p want b0b00002", iss_data); end
    endtask

    task automatic test_timeout;
        stuck = 1'b1;
        pulse(4'b0010, {32'h0, 32'h0, 32'h1111_0001, 32'h0});
        wait_issue(10, "timeout_issue");
        timeout_clr = 1'b1;
        cyc(16);
        n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL timeout_early: got %b want 0 after 15 wait cycles", timeout); end
        cyc(1);
        n_cmp++; if (timeout !== 1'b1) begin n_bad++; $display("FAIL timeout_set_wins: got %b want 1", timeout); end
        timeout_clr = 1'b0;
        cyc(4);
        n_cmp++; if (timeout !== 1'b1) begin n_bad++; $display("FAIL timeout_sticky: got %b want 1", timeout); end
        n_cmp++; if (src_busy !== 4'b0010 || src_done !== 4'b0000) begin n_bad++; $display("FAIL timeout_waiting: busy %b done %b want 0010/0000", src_busy, src_done); end
        n_cmp++; if (grant_id !== 2'd1 || tx_req_data !== 32'h1111_0001) begin n_bad++; $display("FAIL timeout_hold: grant %0d data %h want 1/11110001", grant_id, tx_req_data); end
        timeout_clr = 1'b1;
        cyc(1);
        timeout_clr = 1'b0;
        n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL timeout_clear: got %b want 0", timeout); end
    endtask

    task automatic test_reset_mid_transfer;
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (src_busy !== 4'b0000) begin n_bad++; $display("FAIL async_busy: got %b want 0000", src_busy); end
        n_cmp++; if (grant_id !== 2'd0 || tx_req_data !== 32'h0) begin n_bad++; $display("FAIL async_hold: grant %0d data %h want 0/0", grant_id, tx_req_data); end
        stuck = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(1);
        ev.delete(); iss_data.delete();
        pulse(4'b0001, {32'h0, 32'h0, 32'h0, 32'hC0DE_0000});
        wait_quiet(60, "post_reset_quiet");
        n_cmp++; if (ev.size() != 2 || ev[0] != 10 || ev[1] != 20) begin n_bad++; $display("FAIL post_reset_events: got %p want '{10,20}", ev); end
        n_cmp++; if (iss_data.size() != 1 || iss_data[0] !== 32'hC0DE_0000) begin n_bad++; $display("FAIL post_reset_data: got %p want c0de0000", iss_data); end
    endtask

    task automatic test_back_to_back;
        int exp_ev[$] = '{13, 23, 10, 20, 13, 23};
        int i;
        ev.delete(); iss_data.delete();
        pulse(4'b1000, {32'h3333_0001, 32'h0, 32'h0, 32'h0});
        wait_issue(10, "b2b_issue");
        pulse(4'b0001, {32'h0, 32'h0, 32'h0, 32'h0000_0AAA});
        for (i = 0; i < 60; i++) begin
            if (src_done[3]) break;
            cyc(1);
        end
        if (i == 60) begin
            n_cmp++; n_bad++; $display("FAIL b2b_done: no done for requester 3 within 60 cycles");
        end
        n_cmp++; if (src_busy !== 4'b0001) begin n_bad++; $display("FAIL b2b_done_busy: got %b want 0001", src_busy); end
        pulse(4'b1000, {32'h3333_0002, 32'h0, 32'h0, 32'h0});
        n_cmp++; if (src_busy[3] !== 1'b1) begin n_bad++; $display("FAIL b2b_recapture: busy[3] %b want 1", src_busy[3]); end
        wait_quiet(120, "b2b_quiet");
        n_cmp++;
        if (ev.size() != exp_ev.size()) begin
            n_bad++; $display("FAIL b2b_count: got %p want '{13,23,10,20,13,23}", ev);
        end else begin
            for (int j = 0; j < exp_ev.size(); j++) begin
                n_cmp++; if (ev[j] != exp_ev[j]) begin n_bad++; $display("FAIL b2b_order[%0d]: got %0d want %0d", j, ev[j], exp_ev[j]); end
            end
            n_cmp++; if (iss_data[1] !== 32'h0000_0AAA || iss_data[2] !== 32'h3333_0002) begin n_bad++; $display("FAIL b2b_data: got %h %h want 00000aaa 33330002", iss_data[1], iss_data[2]); end
        end
        n_cmp++; if (dbl != 0) begin n_bad++; $display("FAIL final_pulse_width: got %0d multi-cycle pulses want 0", dbl); end
    endtask

    initial begin
        test_reset;
        test_all_same_cycle;
        test_single;
        test_drop_while_busy;
        test_timeout;
        test_reset_mid_transfer;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
